// File: rtl/pcie_lite_mt.sv
`default_nettype none
// ============================================================================
// pcie_lite_mt : multi-tag MRd/MWr responder with tag table, timeouts, errors
// Rev 1.0
// ============================================================================
module pcie_lite_mt #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NUM_TAGS    = 8,
  parameter int CPL_LATENCY = 16,
  parameter int CPL_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      link_up,
  input  logic                      tlp_valid,
  output logic                      tlp_ready,
  input  logic [2:0]                tlp_type,
  input  logic [31:0]               tlp_address,
  input  logic [DATA_W-1:0]         tlp_data,
  input  logic [7:0]                tlp_tag,
  output logic                      cpl_valid,
  input  logic                      cpl_ready,
  output logic [2:0]                cpl_status,
  output logic [DATA_W-1:0]         cpl_data,
  output logic [7:0]                cpl_tag,
  input  logic                      inject_crc_error,
  input  logic                      inject_timeout,
  input  logic                      inject_malformed_tlp,
  output logic                      err_valid,
  output logic [3:0]                err_type,
  output logic [7:0]                err_tag,
  output logic [$clog2(NUM_TAGS):0] outstanding
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int AGE_W = $clog2(CPL_TIMEOUT + 1);

  localparam logic [2:0]       c_tlp_mrd  = 3'b000;
  localparam logic [2:0]       c_tlp_mwr  = 3'b001;
  localparam logic [2:0]       c_cpl_sc   = 3'b000;
  localparam logic [2:0]       c_cpl_ur   = 3'b001;
  localparam logic [2:0]       c_cpl_ca   = 3'b010;
  localparam logic [3:0]       c_err_crc  = 4'd1;
  localparam logic [3:0]       c_err_to   = 4'd2;
  localparam logic [3:0]       c_err_mal  = 4'd4;
  localparam logic [3:0]       c_err_uns  = 4'd5;
  localparam logic [3:0]       c_err_dup  = 4'd7;
  localparam logic [3:0]       c_err_link = 4'd8;
  localparam logic [AGE_W-1:0] c_age_lat  = AGE_W'(CPL_LATENCY);
  localparam logic [AGE_W-1:0] c_age_to   = AGE_W'(CPL_TIMEOUT);

  // Tag table
  logic [NUM_TAGS-1:0] busy_q, busy_d, ca_q, ca_d, stall_q, stall_d, ur_q, ur_d;
  logic [AGE_W-1:0]    age_q [NUM_TAGS];
  logic [AGE_W-1:0]    age_d [NUM_TAGS];
  logic [7:0]          tag_q [NUM_TAGS];
  logic [7:0]          tag_d [NUM_TAGS];
  logic [AW-1:0]       idx_q [NUM_TAGS];
  logic [AW-1:0]       idx_d [NUM_TAGS];
  logic [DATA_W-1:0]   mem   [MEM_DEPTH];

  logic                link_en_q;
  logic                cpl_valid_q;
  logic [2:0]          cpl_status_q;
  logic [DATA_W-1:0]   cpl_data_q;
  logic [7:0]          cpl_tag_q;
  logic                err_valid_q, err_valid_d;
  logic [3:0]          err_type_q, err_type_d;
  logic [7:0]          err_tag_q, err_tag_d;
  logic [TAG_W:0]      outstanding_q, w_busy_cnt;

  logic                w_acc, w_in_range, w_mal, w_unsup, w_is_rd, w_wr;
  logic                w_dup, w_rd_new, w_crc, w_link_down, w_load, w_to_fire;
  logic                w_sel_found, w_to_found;
  logic [TAG_W-1:0]    w_slot, w_sel_idx, w_to_idx;
  logic                w_unused;

  assign tlp_ready   = link_up && link_en_q;
  assign w_acc       = tlp_valid && tlp_ready;
  assign w_slot      = tlp_tag[TAG_W-1:0];
  assign w_in_range  = (tlp_address[31:AW+2] == '0);
  assign w_mal       = w_acc && inject_malformed_tlp;
  assign w_unsup     = w_acc && !inject_malformed_tlp &&
                       (tlp_type != c_tlp_mrd) && (tlp_type != c_tlp_mwr);
  assign w_is_rd     = w_acc && !inject_malformed_tlp && (tlp_type == c_tlp_mrd);
  assign w_wr        = w_acc && !inject_malformed_tlp && (tlp_type == c_tlp_mwr) && w_in_range;
  assign w_crc       = inject_crc_error && !w_acc;
  assign w_link_down = !link_up && (busy_q != '0);
  assign w_unused    = ^tlp_address[1:0];

  // Lowest eligible completion slot and lowest expired stalled slot
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_to_found  = 1'b0;
    w_to_idx    = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!w_sel_found && busy_q[i] && !stall_q[i] && (age_q[i] == c_age_lat)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = TAG_W'(i);
      end
      if (!w_to_found && busy_q[i] && stall_q[i] && (age_q[i] == c_age_to)) begin
        w_to_found = 1'b1;
        w_to_idx   = TAG_W'(i);
      end
    end
  end

  assign w_load = w_sel_found && (!cpl_valid_q || cpl_ready) && !w_link_down;

  // A slot freed on this edge may be re-accepted without a duplicate report
  assign w_dup    = w_is_rd && busy_q[w_slot] &&
                    !(w_load && (w_sel_idx == w_slot)) &&
                    !(w_to_found && (w_to_idx == w_slot));
  assign w_rd_new = w_is_rd && !w_dup;

  always_comb begin
    err_valid_d = 1'b0;
    err_type_d  = '0;
    err_tag_d   = '0;
    w_to_fire   = 1'b0;
    if (w_link_down) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_link;
    end else if (w_mal) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_mal;
      err_tag_d   = tlp_tag;
    end else if (w_unsup) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_uns;
      err_tag_d   = tlp_tag;
    end else if (w_dup) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_dup;
      err_tag_d   = tlp_tag;
    end else if (w_crc) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_crc;
    end else if (w_to_found) begin
      err_valid_d = 1'b1;
      err_type_d  = c_err_to;
      err_tag_d   = tag_q[w_to_idx];
      w_to_fire   = 1'b1;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    ca_d    = ca_q;
    stall_d = stall_q;
    ur_d    = ur_q;
    age_d   = age_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (busy_q[i] && (stall_q[i] ? (age_q[i] < c_age_to) : (age_q[i] < c_age_lat))) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
    if (w_load)      busy_d[w_sel_idx] = 1'b0;
    if (w_to_fire)   busy_d[w_to_idx]  = 1'b0;
    if (w_link_down) busy_d            = '0;
    if (w_rd_new) begin
      busy_d[w_slot]  = 1'b1;
      age_d[w_slot]   = '0;
      tag_d[w_slot]   = tlp_tag;
      idx_d[w_slot]   = tlp_address[AW+1:2];
      ur_d[w_slot]    = !w_in_range;
      ca_d[w_slot]    = inject_crc_error;
      stall_d[w_slot] = inject_timeout;
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      w_busy_cnt = w_busy_cnt + {{TAG_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_en_q     <= 1'b0;
      busy_q        <= '0;
      ca_q          <= '0;
      stall_q       <= '0;
      ur_q          <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        age_q[i] <= '0;
        tag_q[i] <= '0;
        idx_q[i] <= '0;
      end
      cpl_valid_q   <= 1'b0;
      cpl_status_q  <= '0;
      cpl_data_q    <= '0;
      cpl_tag_q     <= '0;
      err_valid_q   <= 1'b0;
      err_type_q    <= '0;
      err_tag_q     <= '0;
      outstanding_q <= '0;
    end else begin
      link_en_q     <= 1'b1;
      busy_q        <= busy_d;
      ca_q          <= ca_d;
      stall_q       <= stall_d;
      ur_q          <= ur_d;
      age_q         <= age_d;
      tag_q         <= tag_d;
      idx_q         <= idx_d;
      err_valid_q   <= err_valid_d;
      err_type_q    <= err_type_d;
      err_tag_q     <= err_tag_d;
      outstanding_q <= w_busy_cnt;
      if (w_load) begin
        cpl_valid_q  <= 1'b1;
        cpl_tag_q    <= tag_q[w_sel_idx];
        cpl_status_q <= ca_q[w_sel_idx] ? c_cpl_ca : (ur_q[w_sel_idx] ? c_cpl_ur : c_cpl_sc);
        cpl_data_q   <= (ca_q[w_sel_idx] || ur_q[w_sel_idx]) ? '0 : mem[idx_q[w_sel_idx]];
      end else if (cpl_ready) begin
        cpl_valid_q  <= 1'b0;
      end
    end
  end

  // Memory model is not reset; a same-edge read sees the pre-write contents
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem[tlp_address[AW+1:2]] <= tlp_data;
    end
  end

  assign cpl_valid   = cpl_valid_q;
  assign cpl_status  = cpl_status_q;
  assign cpl_data    = cpl_data_q;
  assign cpl_tag     = cpl_tag_q;
  assign err_valid   = err_valid_q;
  assign err_type    = err_type_q;
  assign err_tag     = err_tag_q;
  assign outstanding = outstanding_q;

endmodule
`default_nettype wire
